// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Registered 1-bit full adder with an optional bit-serial carry chain.
//   Each valid cycle adds A + B + cin and registers {carry,sum} one clock
//   later. With chain=1 (and SERIAL_EN=1), cin comes from the carry produced
//   by the previous valid bit, so a multi-bit word can be added LSB first.
//
// Parameters
//   SERIAL_EN  1: honour chain, 0: chain ignored, cin is always C
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   A, B       in   addend bits
//   C          in   external carry-in (used when not chaining)
//   in_valid   in   qualifies A/B/C/chain this cycle
//   chain      in   1 = carry-in from the internal carry register
//   carry      out  registered carry-out
//   sum        out  registered sum bit
//   out_valid  out  carry/sum come from the previous cycle's valid input
// -----------------------------------------------------------------------------
module full_adder #(
   parameter int SERIAL_EN = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic in_valid,
   input  logic chain,
   output logic carry,
   output logic sum,
   output logic out_valid
);

   // The output carry register doubles as the chained carry (carry_q): both
   // load on the same valid edges and clear on the same reset, so a separate
   // copy would always hold the identical value.
   logic r_carry;
   logic r_sum;
   logic r_out_valid;

   logic w_use_chain;
   logic w_cin;
   logic w_sum;
   logic w_carry;

   always_comb begin
      w_use_chain = (SERIAL_EN != 0) && chain;
      w_cin       = w_use_chain ? r_carry : C;
      w_sum       = A ^ B ^ w_cin;
      w_carry     = (A & B) | (A & w_cin) | (B & w_cin);
   end

   // Idle cycles drop out_valid but leave the result registers untouched, so
   // a serial word may be paused between bits without losing its carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_carry     <= 1'b0;
         r_sum       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_carry <= w_carry;
            r_sum   <= w_sum;
         end
      end
   end

   assign carry     = r_carry;
   assign sum       = r_sum;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

   logic clk = 1'b0;
   logic rst_n;
   logic A, B, C, in_valid, chain;
   logic carry, sum, out_valid;
   logic carry0, sum0, out_valid0;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   full_adder #(.SERIAL_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .in_valid(in_valid),
      .chain(chain), .carry(carry), .sum(sum), .out_valid(out_valid)
   );

   full_adder #(.SERIAL_EN(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .in_valid(in_valid),
      .chain(chain), .carry(carry0), .sum(sum0), .out_valid(out_valid0)
   );

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed {ov,carry,sum}=%b expected %b", tag, obs, exp);
      end
   endtask

   // Drive one cycle of input just after a rising edge, then sample 1ns
   // after the following rising edge.
   task automatic step(input logic v, input logic a, input logic b, input logic c, input logic ch);
      in_valid = v; A = a; B = b; C = c; chain = ch;
      @(posedge clk);
      #1;
   endtask

   // Expected {carry,sum} for {A,B,C}=0..7, hand-computed.
   logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; A = 1'b1; B = 1'b1; C = 1'b1; chain = 1'b0;
      #3;
      check("reset_state", {out_valid, carry, sum}, 3'b000);
      check("reset_state_se0", {out_valid0, carry0, sum0}, 3'b000);
      // Inputs are active during reset but must be ignored.
      @(posedge clk); #1;
      check("reset_ignores_inputs", {out_valid, carry, sum}, 3'b000);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Exhaustive, back-to-back (one result per clock, latency 1).
      for (int v = 0; v < 8; v++) begin
         logic [2:0] abc;
         abc = 3'(v);
         step(1'b1, abc[2], abc[1], abc[0], 1'b0);
         check($sformatf("exhaustive_%0d", v), {out_valid, carry, sum}, {1'b1, exp_tab[v]});
      end

      // Hold: 1+1+1, then three idle cycles with junk inputs and chain=1.
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check("hold_load", {out_valid, carry, sum}, 3'b111);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("hold_idle1", {out_valid, carry, sum}, 3'b011);
      step(1'b0, 1'bx, 1'bx, 1'bx, 1'bx);
      check("hold_idle2", {out_valid, carry, sum}, 3'b011);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("hold_idle3", {out_valid, carry, sum}, 3'b011);

      // Asynchronous reset between edges while carry=sum=1.
      #1 rst_n = 1'b0;
      #1;
      check("async_reset", {out_valid, carry, sum}, 3'b000);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Serial 3 + 1 = 4, LSB first.
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("serial_bit0", {out_valid, carry, sum}, 3'b110);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("serial_bit1", {out_valid, carry, sum}, 3'b110);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("serial_bit2", {out_valid, carry, sum}, 3'b101);

      // Chained carry survives an idle gap mid-word.
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("chain_after_gap", {out_valid, carry, sum}, 3'b101);

      // Reset mid-word discards the chained carry; C=1 shows cin is not C.
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("midword_build", {out_valid, carry, sum}, 3'b110);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("midword_reset_chain", {out_valid, carry, sum}, 3'b100);

      // SERIAL_EN=0 ignores chain; SERIAL_EN=1 honours it.
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("se0_build", {out_valid0, carry0, sum0}, 3'b110);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("se0_chain_ignored", {out_valid0, carry0, sum0}, 3'b101);
      check("se1_chain_used", {out_valid, carry, sum}, 3'b110);

      in_valid = 1'b0;
      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
